// File: rtl/seg_display_arbiter_if.sv
// Requester-to-display bus for the seven-segment arbiter.
// The master side drives per-requester levels and values.
// The slave side (the arbiter) returns the owner, display value, blank flag and tick.
interface seg_display_arbiter_if;
  logic [3:0]  req;
  logic [31:0] req_val;
  logic [7:0]  dout;
  logic [3:0]  grant;
  logic        blank;
  logic        tick;

  modport master (
    output req,
    output req_val,
    input  dout,
    input  grant,
    input  blank,
    input  tick
  );

  modport slave (
    input  req,
    input  req_val,
    output dout,
    output grant,
    output blank,
    output tick
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// Priority arbiter sharing one seven-segment display among four requesters,
// with a minimum hold time counted in divider ticks. Outputs are registered:
// one cycle from a sampled request to grant/dout. No backpressure; req is level.
module seg_display_arbiter #(
  parameter int         TICK_DIV   = 800000,
  parameter int         HOLD_TICKS = 20,
  parameter logic [7:0] IDLE_VALUE = 8'h00
) (
  input logic                  clk,
  input logic                  rst,
  seg_display_arbiter_if.slave bus
);

  localparam int         DIV_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [7:0] HOLD_LD = 8'(HOLD_TICKS);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  // Registered state
  state_t           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [7:0]       hold_q,  hold_d;
  logic [7:0]       dout_q,  dout_d;
  logic [3:0]       grant_q, grant_d;
  logic             blank_q, blank_d;
  logic [3:0]       req_prev_q;
  logic [DIV_W-1:0] div_q;
  logic             tick_q;

  // Combinational helpers
  logic [1:0] low_idx;
  logic       any_req;
  logic [3:0] higher_mask;
  logic       preempt;
  logic       own_req;
  logic       own_rise;
  logic       release_ok;

  // Lowest-index active requester wins; index 0 is highest priority.
  function automatic logic [1:0] lowest_idx(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    if (r[0])      idx = 2'd0;
    else if (r[1]) idx = 2'd1;
    else if (r[2]) idx = 2'd2;
    else if (r[3]) idx = 2'd3;
    return idx;
  endfunction

  assign low_idx     = lowest_idx(bus.req);
  assign any_req     = |bus.req;
  // Bits strictly below the current owner are the only ones allowed to preempt.
  assign higher_mask = (4'b0001 << owner_q) - 4'b0001;
  assign preempt     = |(bus.req & higher_mask);
  assign own_req     = bus.req[owner_q];
  assign own_rise    = bus.req[owner_q] & ~req_prev_q[owner_q];
  // Owner may be displaced by anyone once its hold has expired and it has let go.
  assign release_ok  = (hold_q == 8'd0) && !own_req;

  // Free-running tick divider: tick is the registered wrap of the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (div_q == DIV_LAST);
      if (div_q == DIV_LAST) div_q <= '0;
      else                   div_q <= div_q + 1'b1;
    end
  end

  // Next ownership, hold count and display value.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    dout_d  = dout_q;

    unique case (state_q)
      IDLE: begin
        hold_d = 8'd0;
        dout_d = IDLE_VALUE;
        if (any_req) begin
          state_d = OWNED;
          owner_d = low_idx;
          hold_d  = HOLD_LD;
          dout_d  = bus.req_val[{low_idx, 3'b000} +: 8];
        end
      end

      OWNED: begin
        if (preempt || release_ok) begin
          // Preemption and post-hold handover both pick the lowest active
          // requester; a fresh owner always starts with a full hold.
          if (any_req) begin
            owner_d = low_idx;
            hold_d  = HOLD_LD;
            dout_d  = bus.req_val[{low_idx, 3'b000} +: 8];
          end else begin
            state_d = IDLE;
            owner_d = 2'd0;
            hold_d  = 8'd0;
            dout_d  = IDLE_VALUE;
          end
        end else begin
          // Owner keeps the display; a re-press restarts its hold window.
          if (own_rise)
            hold_d = HOLD_LD;
          else if (tick_q && (hold_q != 8'd0))
            hold_d = hold_q - 8'd1;
          if (own_req)
            dout_d = bus.req_val[{owner_q, 3'b000} +: 8];
        end
      end

      default: begin
        state_d = IDLE;
        owner_d = 2'd0;
        hold_d  = 8'd0;
        dout_d  = IDLE_VALUE;
      end
    endcase

    grant_d = (state_d == OWNED) ? (4'b0001 << owner_d) : 4'b0000;
    blank_d = (state_d == IDLE);
  end

  // Ownership state, registered outputs and request edge history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 2'd0;
      hold_q     <= 8'd0;
      dout_q     <= IDLE_VALUE;
      grant_q    <= 4'b0000;
      blank_q    <= 1'b1;
      req_prev_q <= 4'b0000;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      hold_q     <= hold_d;
      dout_q     <= dout_d;
      grant_q    <= grant_d;
      blank_q    <= blank_d;
      req_prev_q <= bus.req;
    end
  end

  assign bus.dout  = dout_q;
  assign bus.grant = grant_q;
  assign bus.blank = blank_q;
  assign bus.tick  = tick_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: two instances (hold 3 and hold 0) driven with
// identical requests, checked against a cycle model built from the ownership
// rules, plus a hand-computed vector table and directed corner sequences.
`timescale 1ns/1ps
module tb_seg_display_arbiter;

  localparam int         TD     = 4;
  localparam logic [7:0] IDLE_V = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_val;

  int vectors     = 0;
  int miscompares = 0;

  seg_display_arbiter_if bus0();
  seg_display_arbiter_if bus1();

  assign bus0.req     = req;
  assign bus0.req_val = req_val;
  assign bus1.req     = req;
  assign bus1.req_val = req_val;

  seg_display_arbiter #(.TICK_DIV(TD), .HOLD_TICKS(3), .IDLE_VALUE(IDLE_V)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  seg_display_arbiter #(.TICK_DIV(TD), .HOLD_TICKS(0), .IDLE_VALUE(IDLE_V)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  always #5 clk = ~clk;

  // Abstract model: owner is -1 when idle, hold is a plain integer.
  typedef struct {
    int         owner;
    int         hold;
    logic [3:0] prev;
    logic [7:0] dout;
    int         cnt;
    logic       tick;
  } mdl_t;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] val;
    logic [3:0]  grant;
    logic [7:0]  dout;
    logic        blank;
  } vec_t;

  mdl_t m0, m1;
  vec_t tbl [7];

  function automatic mdl_t mreset();
    mdl_t s;
    s.owner = -1; s.hold = 0; s.prev = 4'b0; s.dout = IDLE_V; s.cnt = 0; s.tick = 1'b0;
    return s;
  endfunction

  function automatic mdl_t step(mdl_t s, logic [3:0] r, logic [31:0] v, int ht);
    mdl_t n;
    int   lo;
    bit   take;
    n  = s;
    lo = -1;
    for (int i = 3; i >= 0; i--) if (r[i]) lo = i;
    n.tick = (s.cnt == TD - 1);
    n.cnt  = (s.cnt + 1) % TD;
    n.prev = r;
    take = 1'b0;
    if (s.owner < 0) take = 1'b1;
    else if (lo >= 0 && lo < s.owner) take = 1'b1;
    else if (s.hold == 0 && r[s.owner] == 1'b0) take = 1'b1;
    if (take) begin
      if (lo >= 0) begin
        n.owner = lo; n.hold = ht; n.dout = v[8*lo +: 8];
      end else begin
        n.owner = -1; n.hold = 0; n.dout = IDLE_V;
      end
    end else begin
      if (r[s.owner] && !s.prev[s.owner]) n.hold = ht;
      else if (s.tick && s.hold > 0)      n.hold = s.hold - 1;
      if (r[s.owner]) n.dout = v[8*s.owner +: 8];
    end
    return n;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_rng(string name, int act, int lo, int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic check_dut(string tag, mdl_t m, logic [3:0] g, logic [7:0] d, logic b, logic t);
    logic [3:0] eg;
    eg = (m.owner < 0) ? 4'b0000 : (4'b0001 << m.owner);
    chk({tag, " grant"}, 32'(g), 32'(eg));
    chk({tag, " dout"},  32'(d), 32'(m.dout));
    chk({tag, " blank"}, 32'(b), 32'(m.owner < 0));
    chk({tag, " tick"},  32'(t), 32'(m.tick));
  endtask

  task automatic check_models();
    check_dut("hold3", m0, bus0.grant, bus0.dout, bus0.blank, bus0.tick);
    check_dut("hold0", m1, bus1.grant, bus1.dout, bus1.blank, bus1.tick);
  endtask

  // One clock: advance the models on the inputs sampled at the edge, compare after.
  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      m0 = mreset(); m1 = mreset();
    end else begin
      m0 = step(m0, req, req_val, 3);
      m1 = step(m1, req, req_val, 0);
    end
    #1;
    check_models();
  endtask

  // Reset asserted between edges must clear outputs without waiting for a clock.
  task automatic async_reset(int edges);
    #2;
    rst = 1'b1;
    m0 = mreset(); m1 = mreset();
    #1;
    chk("async rst grant", 32'(bus0.grant), 32'h0);
    chk("async rst blank", 32'(bus0.blank), 32'h1);
    chk("async rst dout",  32'(bus0.dout),  32'(IDLE_V));
    chk("async rst tick",  32'(bus0.tick),  32'h0);
    check_models();
    repeat (edges) cycle();
    #2;
    rst = 1'b0;
  endtask

  task automatic go_idle();
    int n;
    req = 4'b0;
    n = 0;
    while (bus0.blank !== 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    chk("go_idle blank", 32'(bus0.blank), 32'h1);
  endtask

  initial begin
    int ticks;
    int owned;
    int k;

    rst = 1'b1; req = 4'b0; req_val = 32'h0;
    m0 = mreset(); m1 = mreset();

    // Hand-computed vectors: outputs after the edge that samples each row.
    tbl[0] = '{4'b0000, 32'h0000_0000, 4'b0000, 8'h00, 1'b1};
    tbl[1] = '{4'b0100, 32'h0042_0000, 4'b0100, 8'h42, 1'b0};
    tbl[2] = '{4'b0100, 32'h0043_0000, 4'b0100, 8'h43, 1'b0};
    tbl[3] = '{4'b1100, 32'h5543_0000, 4'b0100, 8'h43, 1'b0};
    tbl[4] = '{4'b1100, 32'h5544_0000, 4'b0100, 8'h44, 1'b0};
    tbl[5] = '{4'b1101, 32'h5544_0099, 4'b0001, 8'h99, 1'b0};
    tbl[6] = '{4'b1100, 32'h5544_0011, 4'b0001, 8'h99, 1'b0};

    #12;
    chk("reset grant", 32'(bus0.grant), 32'h0);
    chk("reset blank", 32'(bus0.blank), 32'h1);
    chk("reset dout",  32'(bus0.dout),  32'(IDLE_V));
    chk("reset tick",  32'(bus0.tick),  32'h0);
    rst = 1'b0;

    // Idle for 20 cycles: tick every 4th cycle, display blank throughout.
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (bus0.tick === 1'b1) ticks++;
    end
    chk("idle tick count", 32'(ticks), 32'd5);

    for (int i = 0; i < 7; i++) begin
      req = tbl[i].req; req_val = tbl[i].val;
      cycle();
      chk($sformatf("tbl%0d grant", i), 32'(bus0.grant), 32'(tbl[i].grant));
      chk($sformatf("tbl%0d dout", i),  32'(bus0.dout),  32'(tbl[i].dout));
      chk($sformatf("tbl%0d blank", i), 32'(bus0.blank), 32'(tbl[i].blank));
    end

    // Single-cycle pulse holds for three ticks; zero-hold instance releases at once.
    go_idle();
    req = 4'b0010; req_val = 32'h0000_1700;
    cycle();
    chk("pulse grant", 32'(bus0.grant), 32'h2);
    chk("pulse dout",  32'(bus0.dout),  32'h17);
    chk("hold0 pulse grant", 32'(bus1.grant), 32'h2);
    req = 4'b0000;
    owned = 1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (i == 0) chk("hold0 release blank", 32'(bus1.blank), 32'h1);
      if (bus0.grant === 4'b0010) owned++;
      else break;
    end
    chk_rng("pulse owned cycles", owned, 10, 13);
    chk("pulse end blank", 32'(bus0.blank), 32'h1);
    chk("pulse end dout",  32'(bus0.dout),  32'(IDLE_V));

    // Preemption by req[0] over a held req[3], then regrant after the hold.
    req = 4'b1000; req_val = 32'h3300_0000;
    cycle();
    chk("r3 grant", 32'(bus0.grant), 32'h8);
    req = 4'b1001; req_val = 32'h3300_0099;
    cycle();
    chk("preempt grant", 32'(bus0.grant), 32'h1);
    chk("preempt dout",  32'(bus0.dout),  32'h99);
    req = 4'b1000;
    k = 99;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (bus0.grant === 4'b1000) begin k = i; break; end
    end
    chk_rng("regrant delay", k, 10, 13);
    chk("regrant dout", 32'(bus0.dout), 32'h33);

    // Lower-priority requester waits while the owner keeps asserting.
    go_idle();
    req = 4'b0010; req_val = 32'h0000_2100;
    cycle();
    chk("own1 grant", 32'(bus0.grant), 32'h2);
    req = 4'b0110; req_val = 32'h0022_2100;
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk($sformatf("own1 keep %0d", i), 32'(bus0.grant), 32'h2);
    end
    req = 4'b0100;
    cycle();
    chk("handover grant", 32'(bus0.grant), 32'h4);
    chk("handover dout",  32'(bus0.dout),  32'h22);

    // Reset mid-hold while req[0] owns; regrant on the first edge after release.
    go_idle();
    req = 4'b0001; req_val = 32'h0000_005A;
    cycle();
    chk("r0 grant", 32'(bus0.grant), 32'h1);
    cycle(); cycle();
    async_reset(2);
    cycle();
    chk("post rst grant", 32'(bus0.grant), 32'h1);
    chk("post rst dout",  32'(bus0.dout),  32'h5A);

    // Randomised traffic against the model, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 6) == 0) req[b] = ~req[b];
      if ($urandom_range(0, 3) == 0) req_val = $urandom;
      if ($urandom_range(0, 199) == 0) async_reset(1 + $urandom_range(0, 2));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
